timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
Parametrised memory-mapped bank of NUM_CH independent down-counting timers. It replaces the single 32-bit timer register on the core's data bus. It decodes its own address window, so the chipset only needs one select for it. Each channel has a prescaler, one-shot/auto-reload mode, a sticky expiry flag and an interrupt line.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
WIDTH, 32, counter and load register width (8..32)
BASE_ADDR, 32'h0000_0C00, byte base of the window; aligned to 256 bytes

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low
DataAdr  input  32  byte address from core
MemWrite  input  1  write strobe, qualified by address hit
WriteData  input  32  write data
ReadData  output  32  read data, combinational from DataAdr
hit  output  1  DataAdr inside window; drives chipset read mux select
irq  output  NUM_CH  per-channel interrupt, level

Behaviour:
- Window: hit=1 when DataAdr[31:8]==BASE_ADDR[31:8]. Channel index = DataAdr[7:4]. Register = DataAdr[3:2]. DataAdr[1:0] is ignored.
- Registers per channel:
  - 0x0 CTRL: [0] EN, [1] AUTO, [2] IRQ_EN, [15:8] PRESC. Other bits read 0.
  - 0x4 LOAD: WIDTH bits.
  - 0x8 COUNT: WIDTH bits.
  - 0xC STATUS: [0] EXP.
- Reads: combinational. Upper bits above WIDTH read 0. Reads return 0 when hit=0 or channel index >= NUM_CH. Reads have no side effects.
- Writes: take effect on the rising edge when rst=1, MemWrite=1, hit=1 and channel index < NUM_CH. All other writes are ignored.
- Reset (rst=0 at edge): all CTRL/LOAD/COUNT/STATUS and prescaler counters go to 0, so irq=0. A reset mid-count aborts the count immediately. hit and ReadData stay combinational.
- Prescaler: per-channel 8-bit pcnt.
  - When EN=1: a tick occurs in a cycle where pcnt==PRESC; pcnt then wraps to 0. Otherwise pcnt increments.
  - When EN=0: pcnt is held at 0.
- Count on tick:
  - COUNT!=0: COUNT decrements by 1.
  - COUNT==0: EXP is set. If AUTO=1, COUNT<=LOAD. If AUTO=0, EN is cleared and COUNT stays 0.
  - Period in auto mode is (LOAD+1)*(PRESC+1) cycles.
- Write side effects:
  - Write to LOAD also copies the value into COUNT and zeroes pcnt.
  - Write to COUNT sets COUNT directly and zeroes pcnt.
  - Write to CTRL with EN 0->1 zeroes pcnt.
- STATUS is write-1-to-clear. Writing 0 has no effect.
- Collisions in the same cycle:
  - Expiry and W1C of EXP: set wins, EXP stays 1.
  - Tick and CPU write to COUNT or LOAD: the CPU write wins and the tick is dropped.
  - Tick on expiry in one-shot mode and CPU write of CTRL: the CPU-written CTRL value wins.
- irq[i] = EXP[i] & IRQ_EN[i], combinational from registers, so zero added latency after the flag.
- Channels are fully independent. Operating one channel never alters another.

Test Plan:
- Reset: drive rst=0 for 2 cycles with non-zero prior state. Then CTRL/LOAD/COUNT/STATUS all read 0 and irq=0.
- Auto-reload: ch0 LOAD=3, CTRL=0x0007 (PRESC=0). EXP rises 4 cycles after the CTRL write edge, COUNT reads 3 again, irq[0]=1. Write STATUS=1: irq[0]=0 next cycle. The next EXP follows 4 cycles later.
- Prescale one-shot: ch2 LOAD=2, CTRL=0x0301 (PRESC=3, AUTO=0). EXP sets after 12 cycles and EN reads 0. COUNT stays 0 for 20 further cycles. irq[2] stays 0 because IRQ_EN=0.
- Collision: arrange a W1C of STATUS in the same cycle as ch1 expiry. EXP must read 1. Separately, a COUNT write of 0x10 on a tick cycle must read back 0x10.
- Decode: write 0xFFFF_FFFF to BASE_ADDR+0x100, and with NUM_CH=4 to BASE_ADDR+0x40. No register changes. Reads return 0, and hit=0 for the first address only.
- Width: WIDTH=16, write LOAD=0xFFFF_1234. LOAD reads 0x0000_1234 and COUNT reads 0x0000_1234.

Source files
------------

// File: rtl/timer_bank_if.sv
// Core data-bus view of the timer bank: address, write strobe/data, read data and window hit.
interface timer_bank_if;
  logic [31:0] DataAdr;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output DataAdr, MemWrite, WriteData, input ReadData, hit);
  modport slave  (input DataAdr, MemWrite, WriteData, output ReadData, hit);
endinterface

// File: rtl/timer_bank.sv
// Memory-mapped bank of NUM_CH prescaled down-counters with sticky expiry flags and level irqs.
// Reads are combinational from the address; writes and counting take effect on the rising edge.
module timer_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0C00
) (
  input  logic              clk,
  input  logic              rst,
  timer_bank_if.slave       bus,
  output logic [NUM_CH-1:0] irq
);

  localparam logic [4:0] NCH5 = 5'(NUM_CH);

  logic [3:0]  ch_idx;
  logic [1:0]  reg_sel;
  logic        ch_ok;
  logic        wr_ok;
  logic [31:0] wdat;
  logic [31:0] rdata;
  logic        unused_adr;

  logic [NUM_CH-1:0] en_q, en_d, auto_q, auto_d, ie_q, ie_d, exp_q, exp_d;
  logic [NUM_CH-1:0] tick, sel;
  logic [7:0]        presc_q [NUM_CH];
  logic [7:0]        presc_d [NUM_CH];
  logic [7:0]        pcnt_q  [NUM_CH];
  logic [7:0]        pcnt_d  [NUM_CH];
  logic [WIDTH-1:0]  load_q  [NUM_CH];
  logic [WIDTH-1:0]  load_d  [NUM_CH];
  logic [WIDTH-1:0]  cnt_q   [NUM_CH];
  logic [WIDTH-1:0]  cnt_d   [NUM_CH];

  assign bus.hit    = (bus.DataAdr[31:8] == BASE_ADDR[31:8]);
  assign ch_idx     = bus.DataAdr[7:4];
  assign reg_sel    = bus.DataAdr[3:2];
  assign unused_adr = ^bus.DataAdr[1:0];
  assign ch_ok      = ({1'b0, ch_idx} < NCH5);
  assign wr_ok      = bus.MemWrite && bus.hit && ch_ok;
  assign wdat       = bus.WriteData;

  always_comb begin
    en_d   = en_q;
    auto_d = auto_q;
    ie_d   = ie_q;
    exp_d  = exp_q;
    tick   = '0;
    sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      presc_d[i] = presc_q[i];
      load_d[i]  = load_q[i];
      cnt_d[i]   = cnt_q[i];
      sel[i]     = wr_ok && (ch_idx == 4'(i));
      tick[i]    = en_q[i] && (pcnt_q[i] == presc_q[i]);
      pcnt_d[i]  = tick[i] ? 8'd0 : pcnt_q[i] + 8'd1;

      if (tick[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end else begin
          exp_d[i] = 1'b1;
          if (auto_q[i]) cnt_d[i] = load_q[i];
          else           en_d[i]  = 1'b0;
        end
      end

      // CPU writes are applied after the tick so they override it on collision.
      if (sel[i]) begin
        case (reg_sel)
          2'd0: begin
            en_d[i]    = wdat[0];
            auto_d[i]  = wdat[1];
            ie_d[i]    = wdat[2];
            presc_d[i] = wdat[15:8];
            if (!en_q[i] && wdat[0]) pcnt_d[i] = 8'd0;
          end
          2'd1: begin
            load_d[i] = wdat[WIDTH-1:0];
            cnt_d[i]  = wdat[WIDTH-1:0];
            pcnt_d[i] = 8'd0;
          end
          2'd2: begin
            cnt_d[i]  = wdat[WIDTH-1:0];
            pcnt_d[i] = 8'd0;
          end
          default: begin
            if (wdat[0] && !(tick[i] && cnt_q[i] == '0)) exp_d[i] = 1'b0;
          end
        endcase
      end

      if (!en_d[i]) pcnt_d[i] = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q   <= '0;
      auto_q <= '0;
      ie_q   <= '0;
      exp_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        presc_q[i] <= '0;
        pcnt_q[i]  <= '0;
        load_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      en_q   <= en_d;
      auto_q <= auto_d;
      ie_q   <= ie_d;
      exp_q  <= exp_d;
      for (int i = 0; i < NUM_CH; i++) begin
        presc_q[i] <= presc_d[i];
        pcnt_q[i]  <= pcnt_d[i];
        load_q[i]  <= load_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.hit && ch_idx == 4'(i)) begin
        case (reg_sel)
          2'd0:    rdata = {16'd0, presc_q[i], 5'd0, ie_q[i], auto_q[i], en_q[i]};
          2'd1:    rdata[WIDTH-1:0] = load_q[i];
          2'd2:    rdata[WIDTH-1:0] = cnt_q[i];
          default: rdata[0] = exp_q[i];
        endcase
      end
    end
  end

  assign bus.ReadData = rdata;
  assign irq          = exp_q & ie_q;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_timer_bank;
  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'h0000_0C00;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] irq;
  logic [3:0]     irq16;
  int n_tests = 0;
  int n_fail  = 0;

  always #50 clk = ~clk;

  timer_bank_if bus();
  timer_bank_if bus16();

  timer_bank #(.NUM_CH(NCH), .WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .irq(irq));

  timer_bank #(.NUM_CH(4), .WIDTH(16), .BASE_ADDR(BASE)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave), .irq(irq16));

  // Reference model of the 32-bit bank
  logic        m_en [NCH], m_auto [NCH], m_ie [NCH], m_exp [NCH];
  logic [7:0]  m_presc [NCH], m_pcnt [NCH];
  logic [31:0] m_load [NCH], m_cnt [NCH];

  function automatic void mstep(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic rv);
    logic hit_a, tk, wr_here, nen, nexp;
    logic [7:0] np;
    logic [31:0] nc;
    int ch, r;
    hit_a = (a[31:8] == BASE[31:8]);
    ch = int'(a[7:4]);
    r  = int'(a[3:2]);
    for (int c = 0; c < NCH; c++) begin
      if (!rv) begin
        m_en[c] = 0; m_auto[c] = 0; m_ie[c] = 0; m_exp[c] = 0;
        m_presc[c] = 0; m_pcnt[c] = 0; m_load[c] = 0; m_cnt[c] = 0;
        continue;
      end
      tk = m_en[c] && (m_pcnt[c] == m_presc[c]);
      nen = m_en[c]; nexp = m_exp[c]; nc = m_cnt[c];
      np = tk ? 8'd0 : m_pcnt[c] + 8'd1;
      if (tk) begin
        if (m_cnt[c] != 0) nc = m_cnt[c] - 1;
        else begin
          nexp = 1;
          if (m_auto[c]) nc = m_load[c];
          else nen = 0;
        end
      end
      wr_here = we && hit_a && (ch == c);
      if (wr_here) begin
        if (r == 0) begin
          if (!m_en[c] && wd[0]) np = 0;
          nen = wd[0]; m_auto[c] = wd[1]; m_ie[c] = wd[2]; m_presc[c] = wd[15:8];
        end else if (r == 1) begin
          m_load[c] = wd; nc = wd; np = 0;
        end else if (r == 2) begin
          nc = wd; np = 0;
        end else if (wd[0]) begin
          nexp = (tk && m_cnt[c] == 0);
        end
      end
      if (!nen) np = 0;
      m_en[c] = nen; m_exp[c] = nexp; m_cnt[c] = nc; m_pcnt[c] = np;
    end
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    int ch, r;
    ch = int'(a[7:4]);
    r  = int'(a[3:2]);
    if (a[31:8] != BASE[31:8] || ch >= NCH) return 32'd0;
    case (r)
      0: return {16'd0, m_presc[ch], 5'd0, m_ie[ch], m_auto[ch], m_en[ch]};
      1: return m_load[ch];
      2: return m_cnt[ch];
      default: return {31'd0, m_exp[ch]};
    endcase
  endfunction

  function automatic logic [NCH-1:0] mirq();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_exp[c] & m_ie[c];
    return v;
  endfunction

  function automatic logic [31:0] ra(input int ch, input int r);
    return BASE + 32'(ch * 16) + 32'(r * 4);
  endfunction

  task automatic step();
    mstep(bus.DataAdr, bus.MemWrite, bus.WriteData, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.DataAdr = a; bus.WriteData = d; bus.MemWrite = 1'b1;
    step();
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.DataAdr = a;
    #1;
    d = bus.ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    wr(ra(1, 1), 32'd5);
    wr(ra(1, 0), 32'h5);
    wr(ra(2, 2), 32'd9);
    wr(ra(3, 0), 32'h0207);
    rst = 1'b0; step(); step(); rst = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) begin
        rd(ra(c, r), d);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg ch%0d r%0d: got %h want 0", c, r, d); end
      end
    n_tests++;
    if (irq !== '0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    wr(ra(0, 1), 32'd3);
    wr(ra(0, 0), 32'h7);
    step(); step(); step();
    rd(ra(0, 3), d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL auto_early_exp: got %h want 0", d); end
    step();
    rd(ra(0, 3), d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL auto_exp: got %h want 1", d); end
    rd(ra(0, 2), d);
    n_tests++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL auto_reload_cnt: got %h want 3", d); end
    n_tests++;
    if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL auto_irq: got %b want 1", irq[0]); end
    wr(ra(0, 3), 32'd1);
    n_tests++;
    if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL auto_irq_clr: got %b want 0", irq[0]); end
    step(); step();
    rd(ra(0, 3), d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL auto_2nd_early: got %h want 0", d); end
    step();
    rd(ra(0, 3), d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL auto_2nd_exp: got %h want 1", d); end
    wr(ra(0, 0), 32'h0);
    wr(ra(0, 3), 32'h1);
  endtask

  task automatic test_prescale_oneshot();
    logic [31:0] d;
    wr(ra(2, 1), 32'd2);
    wr(ra(2, 0), 32'h0301);
    for (int k = 0; k < 11; k++) step();
    rd(ra(2, 3), d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL presc_early_exp: got %h want 0", d); end
    step();
    rd(ra(2, 3), d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL presc_exp: got %h want 1", d); end
    rd(ra(2, 0), d);
    n_tests++;
    if (d !== 32'h0300) begin n_fail++; $display("FAIL presc_en_clr: got %h want 00000300", d); end
    for (int k = 0; k < 20; k++) begin
      step();
      rd(ra(2, 2), d);
      n_tests++;
      if (d !== 32'd0 || irq[2] !== 1'b0) begin
        n_fail++; $display("FAIL presc_hold cyc%0d: got cnt %h irq %b want 0 0", k, d, irq[2]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(ra(1, 1), 32'd2);
    wr(ra(1, 0), 32'h3);
    step(); step();
    wr(ra(1, 3), 32'd1);
    rd(ra(1, 3), d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL coll_w1c_vs_set: got %h want 1", d); end
    wr(ra(1, 2), 32'h10);
    rd(ra(1, 2), d);
    n_tests++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL coll_cnt_write: got %h want 10", d); end
    step();
    rd(ra(1, 2), d);
    n_tests++;
    if (d !== 32'h0F) begin n_fail++; $display("FAIL coll_cnt_after: got %h want 0f", d); end
    wr(ra(1, 0), 32'h0);
    wr(ra(1, 3), 32'h1);
    wr(ra(3, 1), 32'd1);
    wr(ra(3, 0), 32'h1);
    step();
    wr(ra(3, 0), 32'h0105);
    rd(ra(3, 0), d);
    n_tests++;
    if (d !== 32'h0105) begin n_fail++; $display("FAIL coll_ctrl_wins: got %h want 00000105", d); end
    rd(ra(3, 3), d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL coll_oneshot_exp: got %h want 1", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    wr(BASE + 32'h100, 32'hFFFF_FFFF);
    bus.DataAdr = BASE + 32'h100;
    #1;
    n_tests++;
    if (bus.hit !== 1'b0 || bus.ReadData !== 32'd0) begin
      n_fail++; $display("FAIL decode_out: got hit %b data %h want 0 0", bus.hit, bus.ReadData);
    end
    wr(BASE + 32'h40, 32'hFFFF_FFFF);
    bus.DataAdr = BASE + 32'h40;
    #1;
    n_tests++;
    if (bus.hit !== 1'b1 || bus.ReadData !== 32'd0) begin
      n_fail++; $display("FAIL decode_badch: got hit %b data %h want 1 0", bus.hit, bus.ReadData);
    end
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) begin
        rd(ra(c, r), d);
        n_tests++;
        if (d !== mread(ra(c, r))) begin
          n_fail++; $display("FAIL decode_regs ch%0d r%0d: got %h want %h", c, r, d, mread(ra(c, r)));
        end
      end
  endtask

  task automatic test_width();
    bus16.DataAdr = ra(0, 1); bus16.WriteData = 32'hFFFF_1234; bus16.MemWrite = 1'b1;
    step();
    bus16.MemWrite = 1'b0;
    #1;
    n_tests++;
    if (bus16.ReadData !== 32'h0000_1234) begin n_fail++; $display("FAIL width_load: got %h want 00001234", bus16.ReadData); end
    bus16.DataAdr = ra(0, 2);
    #1;
    n_tests++;
    if (bus16.ReadData !== 32'h0000_1234) begin n_fail++; $display("FAIL width_count: got %h want 00001234", bus16.ReadData); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    int op, r;
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 99));
      a = BASE + 32'($urandom_range(0, 4) << 4) + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
      r = int'(a[3:2]);
      if (op < 2) begin
        rst = 1'b0; step(); rst = 1'b1;
      end else if (op < 40) begin
        if (r == 0) begin d = $urandom; d[15:10] = 6'd0; end
        else if (r == 3) d = $urandom;
        else d = 32'($urandom_range(0, 12));
        wr(a, d);
      end else if (op < 45) begin
        wr(BASE ^ (32'h100 << $urandom_range(0, 23)), $urandom);
      end else begin
        step();
      end
      a = BASE + 32'($urandom_range(0, 5) << 4) + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
      rd(a, d);
      n_tests++;
      if (d !== mread(a)) begin n_fail++; $display("FAIL rand_read it%0d adr %h: got %h want %h", it, a, d, mread(a)); end
      n_tests++;
      if (irq !== mirq()) begin n_fail++; $display("FAIL rand_irq it%0d: got %b want %b", it, irq, mirq()); end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.DataAdr = '0; bus.WriteData = '0; bus.MemWrite = 1'b0;
    bus16.DataAdr = '0; bus16.WriteData = '0; bus16.MemWrite = 1'b0;
    step(); step();
    rst = 1'b1;
    test_reset();
    test_auto_reload();
    test_prescale_oneshot();
    test_collision();
    test_decode();
    test_width();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
